// File: rtl/sonar_ch_arbiter.sv
// ---------------------------------------------------------------------------
// sonar_ch_arbiter
//
// Merges CH_NUM per-hydrophone AXI-Stream sample streams onto the single
// shared highpass FIR input. Every output beat carries its source channel
// index on m_axis_tuser so the downstream filter/demod chain can keep
// channels apart.
//
// Each channel has a one-entry holding buffer. Its ready is simply "buffer
// empty and not in reset", so there is no combinational path from
// m_axis_tready back to any s_axis_tready. A channel can therefore accept at
// most one beat every two cycles, which is far faster than the sample rate.
//
// A single output register feeds m_axis. It is reloaded whenever it is free
// (empty, or being consumed this cycle) and the selected buffer is full, so
// consume and reload in the same cycle give back-to-back beats.
//
// Selection:
//   ORDERED = 1 : strict interleave 0,1,..,CH_NUM-1,0,.. (sel = ptr).
//   ORDERED = 0 : work-conserving round-robin; first full buffer at or after
//                 ptr (with wrap), ptr moves to one past the winner.
//
// Ports:
//   s_axis_aclk    in   clock
//   s_axis_arst    in   synchronous active-high reset
//   s_axis_tdata   in   CH_NUM*DATA_W, channel i at [i*DATA_W +: DATA_W]
//   s_axis_tvalid  in   CH_NUM per-channel valid
//   s_axis_tready  out  CH_NUM per-channel ready
//   m_axis_tdata   out  DATA_W selected sample (passed through unchanged)
//   m_axis_tvalid  out  output valid
//   m_axis_tready  in   downstream ready
//   m_axis_tuser   out  USER_W source channel index of the current beat
// ---------------------------------------------------------------------------
module sonar_ch_arbiter #(
  parameter int CH_NUM  = 4,
  parameter int DATA_W  = 24,
  parameter int USER_W  = 2,
  parameter bit ORDERED = 1'b1
) (
  input  logic                     s_axis_aclk,
  input  logic                     s_axis_arst,
  input  logic [CH_NUM*DATA_W-1:0] s_axis_tdata,
  input  logic [CH_NUM-1:0]        s_axis_tvalid,
  output logic [CH_NUM-1:0]        s_axis_tready,
  output logic [DATA_W-1:0]        m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [USER_W-1:0]        m_axis_tuser
);

  localparam logic [USER_W-1:0] LAST_CH = USER_W'(CH_NUM - 1);

  // Per-channel holding buffers
  logic [CH_NUM-1:0] buf_vld_q;
  logic [CH_NUM-1:0] buf_vld_d;
  logic [DATA_W-1:0] buf_data_q [CH_NUM];
  logic [DATA_W-1:0] in_data    [CH_NUM];
  logic [CH_NUM-1:0] take;
  logic [CH_NUM-1:0] drain;

  // Selection pointer and arbitration result
  logic [USER_W-1:0] ptr_q;
  logic [USER_W-1:0] ptr_d;
  logic [USER_W-1:0] sel;
  logic              sel_vld;
  logic              out_free;
  logic              load;

  // Output register
  logic [DATA_W-1:0] m_tdata_q;
  logic [DATA_W-1:0] m_tdata_d;
  logic [USER_W-1:0] m_tuser_q;
  logic [USER_W-1:0] m_tuser_d;
  logic              m_tvalid_q;
  logic              m_tvalid_d;

  // Ready depends only on local buffer state and reset.
  assign s_axis_tready = ~buf_vld_q & {CH_NUM{~s_axis_arst}};

  genvar gi;
  generate
    for (gi = 0; gi < CH_NUM; gi++) begin : g_ch
      assign in_data[gi] = s_axis_tdata[gi*DATA_W +: DATA_W];
      assign take[gi]    = s_axis_tvalid[gi] & s_axis_tready[gi];
      assign drain[gi]   = load & (sel == USER_W'(gi));
    end
  endgenerate

  // A buffer cannot be filled and drained in the same cycle: take needs the
  // buffer empty, drain needs it full.
  assign buf_vld_d = (buf_vld_q | take) & ~drain;

  generate
    if (ORDERED) begin : g_sel_ordered
      // Other channels wait, full and not ready, until ptr reaches them.
      assign sel = ptr_q;
    end else begin : g_sel_rr
      logic [USER_W-1:0] sel_rr;
      logic [USER_W:0]   cand;
      logic              found;

      // Rotating-priority search starting at ptr. The one extra bit on cand
      // holds ptr+k before the wrap back into 0..CH_NUM-1. With nothing
      // buffered sel falls back to ptr, sel_vld is low and nothing loads.
      always_comb begin
        sel_rr = ptr_q;
        cand   = '0;
        found  = 1'b0;
        for (int k = 0; k < CH_NUM; k++) begin
          cand = {1'b0, ptr_q} + (USER_W+1)'(k);
          if (cand >= (USER_W+1)'(CH_NUM)) begin
            cand = cand - (USER_W+1)'(CH_NUM);
          end
          if (!found && buf_vld_q[cand[USER_W-1:0]]) begin
            sel_rr = cand[USER_W-1:0];
            found  = 1'b1;
          end
        end
      end

      assign sel = sel_rr;
    end
  endgenerate

  assign sel_vld  = buf_vld_q[sel];
  assign out_free = ~m_tvalid_q | m_axis_tready;
  assign load     = out_free & sel_vld;

  // In ordered mode sel == ptr, so "one past the winner" is also the plain
  // ptr increment needed there.
  always_comb begin
    ptr_d = ptr_q;
    if (load) begin
      ptr_d = (sel == LAST_CH) ? '0 : sel + 1'b1;
    end
  end

  // Output register: reload when free, otherwise drop valid once consumed.
  // While stalled (valid & ~ready) nothing changes.
  always_comb begin
    m_tdata_d  = m_tdata_q;
    m_tuser_d  = m_tuser_q;
    m_tvalid_d = m_tvalid_q;
    if (load) begin
      m_tdata_d  = buf_data_q[sel];
      m_tuser_d  = sel;
      m_tvalid_d = 1'b1;
    end else if (m_axis_tready) begin
      m_tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_arst) begin
      buf_vld_q  <= '0;
      ptr_q      <= '0;
      m_tdata_q  <= '0;
      m_tuser_q  <= '0;
      m_tvalid_q <= 1'b0;
    end else begin
      buf_vld_q  <= buf_vld_d;
      ptr_q      <= ptr_d;
      m_tdata_q  <= m_tdata_d;
      m_tuser_q  <= m_tuser_d;
      m_tvalid_q <= m_tvalid_d;
    end
  end

  // Buffer payload needs no reset; it is only observed behind buf_vld_q.
  always_ff @(posedge s_axis_aclk) begin
    for (int i = 0; i < CH_NUM; i++) begin
      if (take[i]) begin
        buf_data_q[i] <= in_data[i];
      end
    end
  end

  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tuser  = m_tuser_q;
  assign m_axis_tvalid = m_tvalid_q;

endmodule

// File: tb/tb_sonar_ch_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for sonar_ch_arbiter. Two instances share clock, reset and input
// data: dut_o (strict interleave) and dut_r (round-robin). Each scenario
// drives only the instance it exercises; the idle one sees tvalid low.
// Inputs are driven 1 ns after the rising edge, outputs sampled on the
// falling edge. The random scenarios use per-channel FIFOs of accepted
// samples as the reference: every output beat must match the oldest
// outstanding sample of its tagged channel, and in ordered mode the tags
// must cycle 0,1,..,CH-1.
// ---------------------------------------------------------------------------
module tb_sonar_ch_arbiter;

  localparam int CH = 4;
  localparam int DW = 24;
  localparam int UW = 2;

  logic             clk = 1'b0;
  logic             arst;
  logic [CH*DW-1:0] s_tdata;
  logic [CH-1:0]    s_tvalid_o, s_tvalid_r;
  logic [CH-1:0]    s_tready_o, s_tready_r;
  logic [DW-1:0]    m_tdata_o, m_tdata_r;
  logic             m_tvalid_o, m_tvalid_r;
  logic             m_tready_o, m_tready_r;
  logic [UW-1:0]    m_tuser_o, m_tuser_r;

  int checks = 0;
  int errors = 0;

  // Random-traffic state: pending source beats and reference FIFOs
  logic [CH-1:0] pend;
  logic [DW-1:0] pdat [CH];
  logic [DW-1:0] sb   [CH][$];
  int            exp_ch;
  int            got;
  logic          prev_stall;
  logic [DW-1:0] prev_d;
  logic [UW-1:0] prev_u;

  always #5 clk = ~clk;

  sonar_ch_arbiter #(.CH_NUM(CH), .DATA_W(DW), .USER_W(UW), .ORDERED(1'b1)) dut_o (
    .s_axis_aclk  (clk),
    .s_axis_arst  (arst),
    .s_axis_tdata (s_tdata),
    .s_axis_tvalid(s_tvalid_o),
    .s_axis_tready(s_tready_o),
    .m_axis_tdata (m_tdata_o),
    .m_axis_tvalid(m_tvalid_o),
    .m_axis_tready(m_tready_o),
    .m_axis_tuser (m_tuser_o)
  );

  sonar_ch_arbiter #(.CH_NUM(CH), .DATA_W(DW), .USER_W(UW), .ORDERED(1'b0)) dut_r (
    .s_axis_aclk  (clk),
    .s_axis_arst  (arst),
    .s_axis_tdata (s_tdata),
    .s_axis_tvalid(s_tvalid_r),
    .s_axis_tready(s_tready_r),
    .m_axis_tdata (m_tdata_r),
    .m_axis_tvalid(m_tvalid_r),
    .m_axis_tready(m_tready_r),
    .m_axis_tuser (m_tuser_r)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_ch(input int ch, input logic [DW-1:0] v);
    s_tdata[ch*DW +: DW] = v;
  endtask

  task automatic do_reset();
    next_cycle();
    arst       = 1'b1;
    s_tvalid_o = '0;
    s_tvalid_r = '0;
    m_tready_o = 1'b1;
    m_tready_r = 1'b1;
    next_cycle();
    next_cycle();
    arst = 1'b0;
  endtask

  // Reset held with every channel presenting data: nothing may be accepted.
  task automatic test_reset();
    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      mid();
      checks++;
      if ({m_tvalid_o, m_tdata_o, m_tuser_o, s_tready_o} !== '0) begin
        errors++;
        $display("FAIL reset_ord c%0d: v=%b d=%h u=%0d rdy=%b, required all 0",
                 c, m_tvalid_o, m_tdata_o, m_tuser_o, s_tready_o);
      end
      checks++;
      if ({m_tvalid_r, m_tdata_r, m_tuser_r, s_tready_r} !== '0) begin
        errors++;
        $display("FAIL reset_rr c%0d: v=%b d=%h u=%0d rdy=%b, required all 0",
                 c, m_tvalid_r, m_tdata_r, m_tuser_r, s_tready_r);
      end
      next_cycle();
    end
    arst = 1'b0;
    mid();
    checks++;
    if (s_tready_o !== 4'b1111 || s_tready_r !== 4'b1111) begin
      errors++;
      $display("FAIL reset_release_ready: got %b/%b, required 1111/1111", s_tready_o, s_tready_r);
    end
  endtask

  task automatic test_ordered_basic();
    logic [DW-1:0] e;
    do_reset();
    for (int i = 0; i < CH; i++) set_ch(i, DW'((i + 1) * 'h11));
    s_tvalid_o = 4'hF;
    mid();
    checks++;
    if (s_tready_o !== 4'hF) begin
      errors++;
      $display("FAIL basic_ready: got %b, required 1111", s_tready_o);
    end
    next_cycle();
    s_tvalid_o = '0;
    mid();
    checks++;
    if (m_tvalid_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency: m_tvalid %b at t+1, required 0", m_tvalid_o);
    end
    for (int k = 0; k < CH; k++) begin
      next_cycle();
      mid();
      e = DW'((k + 1) * 'h11);
      checks++;
      if (m_tvalid_o !== 1'b1 || m_tuser_o !== UW'(k) || m_tdata_o !== e) begin
        errors++;
        $display("FAIL basic_beat%0d: v=%b u=%0d d=%h, required v=1 u=%0d d=%h",
                 k, m_tvalid_o, m_tuser_o, m_tdata_o, k, e);
      end
    end
    next_cycle();
    mid();
    checks++;
    if (m_tvalid_o !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle: m_tvalid %b after last beat, required 0", m_tvalid_o);
    end
  endtask

  // Channel 2 alone must wait for 0 and 1 in ordered mode.
  task automatic test_ordered_wait();
    logic [DW-1:0] a, b;
    logic [UW-1:0] gu [$];
    logic [DW-1:0] gd [$];
    do_reset();
    a = DW'($urandom);
    b = DW'($urandom);
    set_ch(2, 24'hFFF000);
    s_tvalid_o = 4'b0100;
    next_cycle();
    s_tvalid_o = '0;
    for (int c = 0; c < 4; c++) begin
      mid();
      checks++;
      if (m_tvalid_o !== 1'b0 || s_tready_o[2] !== 1'b0) begin
        errors++;
        $display("FAIL wait_hold c%0d: m_tvalid=%b ready2=%b, required 0/0",
                 c, m_tvalid_o, s_tready_o[2]);
      end
      next_cycle();
    end
    for (int c = 0; c < 14; c++) begin
      s_tvalid_o = '0;
      if (c == 0) begin set_ch(0, a); s_tvalid_o = 4'b0001; end
      if (c == 2) begin set_ch(1, b); s_tvalid_o = 4'b0010; end
      mid();
      if (m_tvalid_o && m_tready_o) begin
        gu.push_back(m_tuser_o);
        gd.push_back(m_tdata_o);
      end
      next_cycle();
    end
    s_tvalid_o = '0;
    checks++;
    if (gu.size() != 3) begin
      errors++;
      $display("FAIL wait_count: got %0d beats, required 3", gu.size());
    end else begin
      checks++;
      if (gu[0] !== 2'd0 || gu[1] !== 2'd1 || gu[2] !== 2'd2) begin
        errors++;
        $display("FAIL wait_order: got tuser %0d,%0d,%0d, required 0,1,2", gu[0], gu[1], gu[2]);
      end
      checks++;
      if (gd[0] !== a || gd[1] !== b || $signed(gd[2]) != -4096) begin
        errors++;
        $display("FAIL wait_data: got %h,%h,%0d, required %h,%h,-4096",
                 gd[0], gd[1], $signed(gd[2]), a, b);
      end
    end
  endtask

  task automatic test_rr_select();
    logic [DW-1:0] c0, c2, c3;
    do_reset();
    set_ch(3, 24'h7FFFFF);
    set_ch(1, 24'h800000);
    s_tvalid_r = 4'b1010;
    next_cycle();
    s_tvalid_r = '0;
    mid();
    checks++;
    if (m_tvalid_r !== 1'b0) begin
      errors++;
      $display("FAIL rr_latency: m_tvalid %b at t+1, required 0", m_tvalid_r);
    end
    next_cycle();
    mid();
    checks++;
    if (m_tvalid_r !== 1'b1 || m_tuser_r !== 2'd1 || m_tdata_r !== 24'h800000) begin
      errors++;
      $display("FAIL rr_first: v=%b u=%0d d=%h, required 1/1/800000", m_tvalid_r, m_tuser_r, m_tdata_r);
    end
    next_cycle();
    mid();
    checks++;
    if (m_tvalid_r !== 1'b1 || m_tuser_r !== 2'd3 || m_tdata_r !== 24'h7FFFFF) begin
      errors++;
      $display("FAIL rr_second: v=%b u=%0d d=%h, required 1/3/7fffff", m_tvalid_r, m_tuser_r, m_tdata_r);
    end
    next_cycle();
    mid();
    checks++;
    if (m_tvalid_r !== 1'b0) begin
      errors++;
      $display("FAIL rr_idle: m_tvalid %b, required 0", m_tvalid_r);
    end
    // Pointer must be back at 0: with 0, 2 and 3 waiting, 0 wins first.
    next_cycle();
    c0 = DW'($urandom);
    c2 = DW'($urandom);
    c3 = DW'($urandom);
    set_ch(0, c0);
    set_ch(2, c2);
    set_ch(3, c3);
    s_tvalid_r = 4'b1101;
    next_cycle();
    s_tvalid_r = '0;
    next_cycle();
    mid();
    checks++;
    if (m_tvalid_r !== 1'b1 || m_tuser_r !== 2'd0 || m_tdata_r !== c0) begin
      errors++;
      $display("FAIL rr_ptr0: v=%b u=%0d d=%h, required 1/0/%h", m_tvalid_r, m_tuser_r, m_tdata_r, c0);
    end
    next_cycle();
    mid();
    checks++;
    if (m_tuser_r !== 2'd2 || m_tdata_r !== c2) begin
      errors++;
      $display("FAIL rr_ptr2: u=%0d d=%h, required 2/%h", m_tuser_r, m_tdata_r, c2);
    end
    next_cycle();
    mid();
    checks++;
    if (m_tuser_r !== 2'd3 || m_tdata_r !== c3) begin
      errors++;
      $display("FAIL rr_ptr3: u=%0d d=%h, required 3/%h", m_tuser_r, m_tdata_r, c3);
    end
  endtask

  // Fill all four buffers plus the output register on dut_o with tready low.
  task automatic fill_ordered(output logic [DW-1:0] d [5]);
    for (int i = 0; i < 5; i++) d[i] = DW'($urandom);
    m_tready_o = 1'b0;
    for (int i = 0; i < CH; i++) set_ch(i, d[i]);
    s_tvalid_o = 4'hF;
    next_cycle();
    s_tvalid_o = '0;
    next_cycle();
    set_ch(0, d[4]);
    s_tvalid_o = 4'b0001;
    mid();
    checks++;
    if (s_tready_o !== 4'b0001) begin
      errors++;
      $display("FAIL fill_ready: got %b, required 0001", s_tready_o);
    end
    next_cycle();
    s_tvalid_o = '0;
  endtask

  task automatic test_stall();
    logic [DW-1:0] d [5];
    do_reset();
    fill_ordered(d);
    for (int c = 0; c < 6; c++) begin
      mid();
      checks++;
      if (m_tvalid_o !== 1'b1 || m_tdata_o !== d[0] || m_tuser_o !== 2'd0 || s_tready_o !== 4'b0000) begin
        errors++;
        $display("FAIL stall_hold c%0d: v=%b d=%h u=%0d rdy=%b, required 1/%h/0/0000",
                 c, m_tvalid_o, m_tdata_o, m_tuser_o, s_tready_o, d[0]);
      end
      next_cycle();
    end
    m_tready_o = 1'b1;
    for (int k = 0; k < 5; k++) begin
      mid();
      checks++;
      if (m_tvalid_o !== 1'b1 || m_tuser_o !== UW'(k % CH) || m_tdata_o !== d[k]) begin
        errors++;
        $display("FAIL stall_b2b%0d: v=%b u=%0d d=%h, required 1/%0d/%h",
                 k, m_tvalid_o, m_tuser_o, m_tdata_o, k % CH, d[k]);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d [5];
    logic [DW-1:0] n [CH];
    logic [UW-1:0] gu [$];
    logic [DW-1:0] gd [$];
    do_reset();
    fill_ordered(d);
    arst = 1'b1;
    mid();
    checks++;
    if (s_tready_o !== 4'b0000 || s_tready_r !== 4'b0000) begin
      errors++;
      $display("FAIL rstmid_ready: got %b/%b, required 0000/0000", s_tready_o, s_tready_r);
    end
    next_cycle();
    arst = 1'b0;
    m_tready_o = 1'b1;
    mid();
    checks++;
    if (m_tvalid_o !== 1'b0 || m_tdata_o !== '0 || m_tuser_o !== 2'd0) begin
      errors++;
      $display("FAIL rstmid_out: v=%b d=%h u=%0d, required 0/0/0", m_tvalid_o, m_tdata_o, m_tuser_o);
    end
    next_cycle();
    for (int i = 0; i < CH; i++) begin
      n[i] = DW'($urandom);
      set_ch(i, n[i]);
    end
    // Drive channel 0 last in the vector order but all at once.
    s_tvalid_o = 4'hF;
    for (int c = 0; c < 10; c++) begin
      mid();
      if (m_tvalid_o && m_tready_o) begin
        gu.push_back(m_tuser_o);
        gd.push_back(m_tdata_o);
      end
      next_cycle();
      s_tvalid_o = '0;
    end
    checks++;
    if (gu.size() != CH) begin
      errors++;
      $display("FAIL rstmid_count: got %0d beats, required %0d", gu.size(), CH);
    end else begin
      for (int k = 0; k < CH; k++) begin
        checks++;
        if (gu[k] !== UW'(k) || gd[k] !== n[k]) begin
          errors++;
          $display("FAIL rstmid_beat%0d: u=%0d d=%h, required %0d/%h", k, gu[k], gd[k], k, n[k]);
        end
      end
    end
  endtask

  // One cycle of random traffic on the chosen instance with scoreboarding.
  task automatic random_cycle(input bit rr, input bit gen_on, input bit force_rdy);
    logic          rdy, tv;
    logic [UW-1:0] tu;
    logic [DW-1:0] td;
    logic [CH-1:0] sr;
    for (int i = 0; i < CH; i++) begin
      if (gen_on && !pend[i] && $urandom_range(1, 0) == 1) begin
        pend[i] = 1'b1;
        pdat[i] = DW'($urandom);
      end
      set_ch(i, pdat[i]);
    end
    rdy = force_rdy ? 1'b1 : ($urandom_range(3, 0) != 0);
    if (rr) begin
      s_tvalid_r = pend; m_tready_r = rdy; s_tvalid_o = '0;
    end else begin
      s_tvalid_o = pend; m_tready_o = rdy; s_tvalid_r = '0;
    end
    mid();
    tv = rr ? m_tvalid_r : m_tvalid_o;
    tu = rr ? m_tuser_r  : m_tuser_o;
    td = rr ? m_tdata_r  : m_tdata_o;
    sr = rr ? s_tready_r : s_tready_o;
    if (prev_stall) begin
      checks++;
      if (tv !== 1'b1 || td !== prev_d || tu !== prev_u) begin
        errors++;
        $display("FAIL rand_stable: v=%b u=%0d d=%h, required 1/%0d/%h", tv, tu, td, prev_u, prev_d);
      end
    end
    for (int i = 0; i < CH; i++) begin
      if (pend[i] && sr[i]) begin
        sb[i].push_back(pdat[i]);
        pend[i] = 1'b0;
      end
    end
    if (tv && rdy) begin
      checks++;
      if (sb[int'(tu)].size() == 0 || sb[int'(tu)][0] !== td) begin
        errors++;
        $display("FAIL rand_data: ch%0d got %h, required %h (outstanding %0d)", tu, td,
                 (sb[int'(tu)].size() == 0) ? '0 : sb[int'(tu)][0], sb[int'(tu)].size());
      end
      if (sb[int'(tu)].size() != 0) void'(sb[int'(tu)].pop_front());
      if (!rr) begin
        checks++;
        if (tu !== UW'(exp_ch)) begin
          errors++;
          $display("FAIL rand_order: tuser %0d, required %0d", tu, exp_ch);
        end
        exp_ch = (exp_ch + 1) % CH;
      end
      got++;
    end
    prev_stall = tv && !rdy;
    prev_d     = td;
    prev_u     = tu;
    next_cycle();
  endtask

  task automatic test_random(input bit rr, input int nbeats);
    int cyc;
    do_reset();
    pend       = '0;
    got        = 0;
    exp_ch     = 0;
    prev_stall = 1'b0;
    for (int i = 0; i < CH; i++) begin
      sb[i].delete();
      pdat[i] = '0;
    end
    cyc = 0;
    while (got < nbeats && cyc < 5 * nbeats) begin
      random_cycle(rr, 1'b1, 1'b0);
      cyc++;
    end
    checks++;
    if (got < nbeats) begin
      errors++;
      $display("FAIL rand_timeout rr=%0d: %0d beats in %0d cycles, required %0d", rr, got, cyc, nbeats);
    end
    for (int c = 0; c < 40; c++) random_cycle(rr, 1'b0, 1'b1);
    for (int i = 0; i < CH; i++) begin
      checks++;
      if (sb[i].size() != 0 || pend[i] !== 1'b0) begin
        errors++;
        $display("FAIL rand_drain rr=%0d ch%0d: %0d outstanding, pending %b, required 0/0",
                 rr, i, sb[i].size(), pend[i]);
      end
    end
  endtask

  initial begin
    arst       = 1'b1;
    s_tdata    = {$urandom, $urandom, $urandom};
    s_tvalid_o = '1;
    s_tvalid_r = '1;
    m_tready_o = 1'b1;
    m_tready_r = 1'b1;
    test_reset();
    test_ordered_basic();
    test_ordered_wait();
    test_rr_select();
    test_stall();
    test_reset_mid();
    test_random(1'b0, 10000);
    test_random(1'b1, 3000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
